// File: rtl/lsu_mc_if.sv
// Bundle between the LSU, the hart's execute stage and the data memory.
// slave = the LSU itself; master = the core/memory environment driving it.
interface lsu_mc_if #(
   parameter int ADDR_W = 32
);
   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_wen;
   logic [2:0]        i_req_funct3;
   logic [ADDR_W-1:0] i_req_addr;
   logic [31:0]       i_req_wdata;
   logic              o_rsp_valid;
   logic [31:0]       o_rsp_rdata;
   logic              o_rsp_trap;
   logic              o_mem_req;
   logic              i_mem_ready;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_ren;
   logic              o_mem_wen;
   logic [31:0]       o_mem_wdata;
   logic [3:0]        o_mem_mask;
   logic              i_mem_valid;
   logic [31:0]       i_mem_rdata;

   modport slave (
      input  i_req_valid, i_req_wen, i_req_funct3, i_req_addr, i_req_wdata,
             i_mem_ready, i_mem_valid, i_mem_rdata,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap,
             o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask
   );

   modport master (
      output i_req_valid, i_req_wen, i_req_funct3, i_req_addr, i_req_wdata,
             i_mem_ready, i_mem_valid, i_mem_rdata,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap,
             o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask
   );
endinterface

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit, one outstanding handshaked memory access.
// Optional macro LSU_MISALIGNED_SPLIT_EN: misaligned accesses are performed (word-crossers split in two).
module lsu_mc #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input logic     i_clk,
   input logic     i_rst,
   lsu_mc_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ0  = 3'd1;
   localparam logic [2:0] S_WAIT0 = 3'd2;
   localparam logic [2:0] S_REQ1  = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [2:0]        state;
   logic [ADDR_W-1:0] r_addr, mem_addr;
   logic [31:0]       r_wdata, r_rd0, mem_wdata, rsp_rdata;
   logic [1:0]        r_size;
   logic              r_uns, r_wen, r_cross, rsp_trap;
   logic [3:0]        mem_mask;
   logic [CW-1:0]     tcnt;

   function automatic logic [3:0] base_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Accept-time decode straight off the request so phase 0 is ready in REQ0.
   logic [1:0]  d_size, d_k;
   logic        d_illegal, d_fault, d_cross;
   logic [3:0]  d_mask0;
   logic [31:0] d_wdata0;

   always_comb begin
      d_size = bus.i_req_funct3[1:0];
      d_k    = bus.i_req_addr[1:0];
      if (bus.i_req_wen) d_illegal = bus.i_req_funct3[2] || (d_size == 2'd3);
      else               d_illegal = (d_size == 2'd3) || (bus.i_req_funct3 == 3'b110);
`ifdef LSU_MISALIGNED_SPLIT_EN
      d_fault = d_illegal;
      case (d_size)
         2'd0:    d_cross = 1'b0;
         2'd1:    d_cross = (d_k == 2'd3);
         default: d_cross = (d_k != 2'd0);
      endcase
`else
      d_fault = d_illegal || (d_size == 2'd1 && d_k[0]) || (d_size == 2'd2 && d_k != 2'd0);
      d_cross = 1'b0;
`endif
      d_mask0  = base_mask(d_size) << d_k;
      d_wdata0 = bus.i_req_wdata << {d_k, 3'b000};
   end

   // Phase-1 lanes are the bits that fell off the top of the phase-0 shift.
   logic [5:0]  hi_sh;
   logic [3:0]  p1_mask;
   logic [31:0] p1_wdata, ld_lo, ld_hi, joined, ld_ext;
   logic        to_hit;

   always_comb begin
      hi_sh    = 6'd32 - {1'b0, r_addr[1:0], 3'b000};
      p1_mask  = base_mask(r_size) >> (3'd4 - {1'b0, r_addr[1:0]});
      p1_wdata = r_wdata >> hi_sh;
      ld_lo    = r_cross ? r_rd0 : bus.i_mem_rdata;
      ld_hi    = r_cross ? bus.i_mem_rdata : 32'd0;
      joined   = (ld_lo >> {r_addr[1:0], 3'b000}) | (ld_hi << hi_sh);
      case (r_size)
         2'd0:    ld_ext = r_uns ? {24'd0, joined[7:0]}  : {{24{joined[7]}}, joined[7:0]};
         2'd1:    ld_ext = r_uns ? {16'd0, joined[15:0]} : {{16{joined[15]}}, joined[15:0]};
         default: ld_ext = joined;
      endcase
      to_hit = (TIMEOUT != 0) && (tcnt == CW'(TO_LAST));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd0     <= '0;
         r_size    <= '0;
         r_uns     <= 1'b0;
         r_wen     <= 1'b0;
         r_cross   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_mask  <= '0;
         rsp_rdata <= '0;
         rsp_trap  <= 1'b0;
         tcnt      <= '0;
      end else begin
         rsp_rdata <= '0;
         rsp_trap  <= 1'b0;
         case (state)
            S_IDLE: if (bus.i_req_valid) begin
               r_addr  <= bus.i_req_addr;
               r_wdata <= bus.i_req_wdata;
               r_size  <= d_size;
               r_uns   <= bus.i_req_funct3[2];
               r_wen   <= bus.i_req_wen;
               r_cross <= d_cross;
               if (d_fault) begin
                  state    <= S_RESP;
                  rsp_trap <= 1'b1;
               end else begin
                  state     <= S_REQ0;
                  mem_addr  <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
                  mem_mask  <= d_mask0;
                  mem_wdata <= d_wdata0;
               end
            end
            S_REQ0, S_REQ1: if (bus.i_mem_ready) begin
               state     <= (state == S_REQ0) ? S_WAIT0 : S_WAIT1;
               mem_addr  <= '0;
               mem_mask  <= '0;
               mem_wdata <= '0;
               tcnt      <= '0;
            end
            S_WAIT0, S_WAIT1: begin
               if (bus.i_mem_valid) begin
                  if (state == S_WAIT0 && r_cross) begin
                     state     <= S_REQ1;
                     r_rd0     <= bus.i_mem_rdata;
                     mem_addr  <= {r_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                     mem_mask  <= p1_mask;
                     mem_wdata <= p1_wdata;
                  end else begin
                     state     <= S_RESP;
                     rsp_rdata <= r_wen ? 32'd0 : ld_ext;
                  end
               end else if (to_hit) begin
                  // A timed-out phase-1 store leaves phase 0 written.
                  state    <= S_RESP;
                  rsp_trap <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_req_ready = (state == S_IDLE);
   assign bus.o_rsp_valid = (state == S_RESP);
   assign bus.o_rsp_rdata = rsp_rdata;
   assign bus.o_rsp_trap  = rsp_trap;
   assign bus.o_mem_req   = (state == S_REQ0) || (state == S_REQ1);
   assign bus.o_mem_ren   = bus.o_mem_req && !r_wen;
   assign bus.o_mem_wen   = bus.o_mem_req && r_wen;
   assign bus.o_mem_addr  = mem_addr;
   assign bus.o_mem_wdata = mem_wdata;
   assign bus.o_mem_mask  = mem_mask;
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: byte-addressed memory model plus reference predictor; directed cases then random ops.
module tb_lsu_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_mc_if #(.ADDR_W(32)) bus ();
   lsu_mc #(.ADDR_W(32), .TIMEOUT(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   bit [7:0] dev_mem [bit [31:0]];
   bit [7:0] ref_mem [bit [31:0]];

   function automatic bit [7:0] pat(input bit [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction
   function automatic bit [7:0] dev_rd(input bit [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : pat(a);
   endfunction
   function automatic bit [7:0] ref_rd(input bit [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction
   task automatic poke(input bit [31:0] a, input bit [31:0] w);
      for (int i = 0; i < 4; i++) begin
         dev_mem[a + i] = w[8*i +: 8];
         ref_mem[a + i] = w[8*i +: 8];
      end
   endtask

   // memory responder state
   bit          mem_fast = 1'b1;
   bit          mem_hang = 1'b0;
   bit          inject_valid = 1'b0;
   int          fixed_lat = 0;
   bit          cur_wen = 1'b0;
   int          n_hs = 0;
   logic [31:0] hs_addr [$];
   logic [3:0]  hs_mask [$];
   logic [31:0] hs_wdata [$];

   initial begin
      bit          busy;
      int          lat_cnt;
      logic [31:0] pend, a;
      busy = 1'b0; lat_cnt = 0; pend = '0;
      bus.i_mem_ready = 1'b0;
      bus.i_mem_valid = 1'b0;
      bus.i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.i_mem_valid = 1'b0;
         bus.i_mem_rdata = '0;
         if (inject_valid) begin
            bus.i_mem_valid = 1'b1;
            bus.i_mem_rdata = 32'hBAD0_BAD0;
            inject_valid = 1'b0;
         end
         if (busy) begin
            if (lat_cnt == 0) begin
               bus.i_mem_valid = 1'b1;
               bus.i_mem_rdata = pend;
               busy = 1'b0;
            end else lat_cnt--;
         end
         bus.i_mem_ready = mem_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
         // handshake completes on the coming posedge
         if (!busy && !rst && bus.o_mem_req === 1'b1 && bus.i_mem_ready) begin
            a = bus.o_mem_addr;
            n_hs++;
            hs_addr.push_back(a);
            hs_mask.push_back(bus.o_mem_mask);
            hs_wdata.push_back(bus.o_mem_wdata);
            chk("mem_align", {62'd0, a[1:0]}, 64'd0);
            chk("mem_strobe", {62'd0, bus.o_mem_ren, bus.o_mem_wen}, cur_wen ? 64'd1 : 64'd2);
            if (bus.o_mem_wen)
               for (int i = 0; i < 4; i++)
                  if (bus.o_mem_mask[i]) dev_mem[a + i] = bus.o_mem_wdata[8*i +: 8];
            pend = {dev_rd(a + 3), dev_rd(a + 2), dev_rd(a + 1), dev_rd(a)};
            if (!mem_hang) begin
               busy = 1'b1;
               lat_cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
            end
         end
      end
   end

   // issue at a negedge with the LSU idle; returns at the negedge after the response cycle
   task automatic do_op(input bit wen, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        output int cyc, output logic [31:0] rd, output logic tr);
      chk("req_ready", {63'd0, bus.o_req_ready}, 64'd1);
      cur_wen          = wen;
      bus.i_req_valid  = 1'b1;
      bus.i_req_wen    = wen;
      bus.i_req_funct3 = f3;
      bus.i_req_addr   = a;
      bus.i_req_wdata  = wd;
      @(negedge clk);
      bus.i_req_valid  = 1'b0;
      bus.i_req_wen    = $urandom_range(0, 1);
      bus.i_req_funct3 = 3'($urandom);
      bus.i_req_addr   = $urandom;
      bus.i_req_wdata  = $urandom;
      cyc = 1;
      while (bus.o_rsp_valid !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("rsp_seen", {63'd0, bus.o_rsp_valid}, 64'd1);
      rd = bus.o_rsp_rdata;
      tr = bus.o_rsp_trap;
      @(negedge clk);
      chk("rsp_pulse", {63'd0, bus.o_rsp_valid}, 64'd0);
   endtask

   function automatic bit legal(input bit wen, input bit [2:0] f3);
      if (wen) return f3 <= 3'd2;
      return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   endfunction

   // reference: access viewed as nb consecutive bytes starting at a
   task automatic op(input bit wen, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     output int cyc);
      int          nb, ehs, hs0;
      bit          mis, etrap;
      bit [31:0]   v, erd;
      logic [31:0] rd;
      logic        tr;
      logic [63:0] dw, rw;
      nb    = 1 << f3[1:0];
      mis   = (a % nb) != 0;
      etrap = !legal(wen, f3) || (mis && !SPLIT);
      v = '0;
      for (int i = 0; i < nb && i < 4; i++) v |= 32'(ref_rd(a + i)) << (8 * i);
      if (f3[2] || nb == 4) erd = v;
      else if (nb == 1)     erd = {{24{v[7]}}, v[7:0]};
      else                  erd = {{16{v[15]}}, v[15:0]};
      if (etrap || wen) erd = '0;
      ehs = etrap ? 0 : (((a % 4) + nb > 4) ? 2 : 1);
      if (!etrap && wen)
         for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
      hs0 = n_hs;
      hs_addr.delete(); hs_mask.delete(); hs_wdata.delete();
      do_op(wen, f3, a, wd, cyc, rd, tr);
      chk("trap", {63'd0, tr}, {63'd0, etrap});
      chk("rdata", {32'd0, rd}, {32'd0, erd});
      chk("n_mem_req", 64'(n_hs - hs0), 64'(ehs));
      for (int i = 0; i < 8; i++) begin
         dw[8*i +: 8] = dev_rd(a - 2 + i);
         rw[8*i +: 8] = ref_rd(a - 2 + i);
      end
      chk("mem_bytes", dw, rw);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          cyc;
      logic [31:0] rd;
      logic        tr;
      bus.i_req_valid = 1'b0; bus.i_req_wen = 1'b0; bus.i_req_funct3 = '0;
      bus.i_req_addr = '0; bus.i_req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'd0, bus.o_req_ready}, 64'd1);
      chk("rst_rsp",   {61'd0, bus.o_rsp_valid, bus.o_rsp_trap, bus.o_mem_req}, 64'd0);
      chk("rst_strb",  {62'd0, bus.o_mem_ren, bus.o_mem_wen}, 64'd0);
      chk("rst_rdata", {32'd0, bus.o_rsp_rdata}, 64'd0);
      chk("rst_addr",  {32'd0, bus.o_mem_addr}, 64'd0);
      chk("rst_wdata", {28'd0, bus.o_mem_mask, bus.o_mem_wdata}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      mem_fast = 1'b1; fixed_lat = 1;
      poke(32'h1000, 32'hDEADBEEF);
      op(1'b0, 3'b010, 32'h1000, 32'h0, cyc);
      chk("lw_lat", 64'(cyc), 64'd4);
      chk("lw_mask", {60'd0, hs_mask[0]}, 64'hF);
      fixed_lat = 0;
      op(1'b0, 3'b010, 32'h1000, 32'h0, cyc);
      chk("lw_lat_fast", 64'(cyc), 64'd3);
      poke(32'h1000, 32'hAB000000);
      op(1'b0, 3'b100, 32'h1003, 32'h0, cyc);
      chk("lbu_mask", {60'd0, hs_mask[0]}, 64'h8);
      poke(32'h1000, 32'h80010000);
      op(1'b0, 3'b001, 32'h1002, 32'h0, cyc);
      chk("lh_mask", {60'd0, hs_mask[0]}, 64'hC);

      op(1'b1, 3'b010, 32'h2003, 32'h11223344, cyc);
`ifdef LSU_MISALIGNED_SPLIT_EN
      chk("sw_split_lat", 64'(cyc), 64'd5);
      chk("sw_p0", {hs_addr[0], hs_wdata[0]}, {32'h2000, 32'h44000000});
      chk("sw_p1", {hs_addr[1], hs_wdata[1]}, {32'h2004, 32'h00112233});
      chk("sw_masks", {56'd0, hs_mask[0], hs_mask[1]}, 64'h87);
`else
      chk("sw_mis_lat", 64'(cyc), 64'd1);
`endif
      op(1'b0, 3'b011, 32'h1000, 32'h0, cyc);
      chk("ill_lat", 64'(cyc), 64'd1);
      op(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000BEEF, cyc);
`ifdef LSU_MISALIGNED_SPLIT_EN
      chk("sh_wrap_p1", {28'd0, hs_mask[1], hs_addr[1]}, {28'd0, 4'b0001, 32'h0});
      chk("sh_wrap_p0", {28'd0, hs_mask[0], hs_addr[0]}, {28'd0, 4'b1000, 32'hFFFF_FFFC});
`endif

      // watchdog on a memory that never answers
      mem_hang = 1'b1;
      do_op(1'b0, 3'b010, 32'h1000, 32'h0, cyc, rd, tr);
      chk("to_lat", 64'(cyc), 64'd10);
      chk("to_trap", {31'd0, tr, rd}, {31'd0, 1'b1, 32'd0});
      chk("to_ready", {63'd0, bus.o_req_ready}, 64'd1);

      // reset while waiting, then a stale completion
      bus.i_req_valid = 1'b1; bus.i_req_wen = 1'b0; cur_wen = 1'b0;
      bus.i_req_funct3 = 3'b010; bus.i_req_addr = 32'h1000;
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      inject_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rrst_rsp", {61'd0, bus.o_rsp_valid, bus.o_rsp_trap, bus.o_mem_req}, 64'd0);
         chk("rrst_ready", {63'd0, bus.o_req_ready}, 64'd1);
         chk("rrst_bus", {bus.o_mem_addr, bus.o_mem_wdata}, 64'd0);
         chk("rrst_misc", {26'd0, bus.o_mem_mask, bus.o_mem_ren, bus.o_mem_wen, bus.o_rsp_rdata}, 64'd0);
      end
      mem_hang = 1'b0;

      mem_fast = 1'b0; fixed_lat = -1;
      for (int n = 0; n < 300; n++) begin
         bit [31:0] a;
         a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                         : 32'h1000 + $urandom_range(0, 31);
         op(1'($urandom), 3'($urandom), a, $urandom, cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
